// File: rtl/mem_access_unit_if.sv
// Memory access unit port bundle: M-stage request, data bus and response.
// The slave modport is the unit's view; master is the pipeline/bus side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic [2:0]  req_option;
  logic        flush;
  logic        req_ready;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_addr_low2bit;
  logic [2:0]  rsp_option;
  logic        rsp_adel;
  logic        rsp_ades;
  logic        rsp_bus_err;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  req_size, req_option, flush,
    output req_ready,
    output bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
    input  bus_ack, bus_rdata,
    output rsp_valid, rsp_data, rsp_addr_low2bit, rsp_option,
    output rsp_adel, rsp_ades, rsp_bus_err
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output req_size, req_option, flush,
    input  req_ready,
    input  bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
    output bus_ack, bus_rdata,
    input  rsp_valid, rsp_data, rsp_addr_low2bit, rsp_option,
    input  rsp_adel, rsp_ades, rsp_bus_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// M-stage memory access unit: IDLE/BUSY/RESP bus sequencer with alignment checks.
// Define MEM_TIMEOUT_EN to abort a BUSY transfer after TIMEOUT_CYCLES without ack.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_access_unit_if.slave  io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic [2:0]  r_option;
  logic        r_adel;
  logic        r_ades;
  logic        r_flushed;
  logic        r_berr;

  logic [31:0] r_rsp_data;
  logic [1:0]  r_rsp_low2;
  logic [2:0]  r_rsp_option;

  logic        w_accept;
  logic        w_mis;
  logic        w_busy;
  logic        w_timeout;
  logic        w_show;
  logic        w_drop;
  logic [3:0]  w_byteen;
  logic [31:0] w_wdata;

  assign w_busy   = (r_state == BUSY);
  assign w_accept = (r_state == IDLE) && io.req_valid && !io.flush;

  always_comb begin
    w_mis = 1'b0;
    unique case (io.req_size)
      2'b00:   w_mis = 1'b0;
      2'b01:   w_mis = io.req_addr[0];
      default: w_mis = |io.req_addr[1:0];
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [31:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign w_timeout = w_busy && !io.bus_ack &&
                     (r_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = w_mis ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (io.bus_ack || w_timeout) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // A flush seen on the finishing edge also kills the response.
  assign w_drop = r_flushed || io.flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= '0;
      r_option     <= '0;
      r_adel       <= 1'b0;
      r_ades       <= 1'b0;
      r_flushed    <= 1'b0;
      r_berr       <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_low2   <= '0;
      r_rsp_option <= '0;
    end else if (w_accept) begin
      r_we      <= io.req_we;
      r_addr    <= io.req_addr;
      r_wdata   <= io.req_wdata;
      r_size    <= io.req_size;
      r_option  <= io.req_option;
      r_adel    <= w_mis && !io.req_we;
      r_ades    <= w_mis && io.req_we;
      r_flushed <= 1'b0;
      r_berr    <= 1'b0;
      if (w_mis) begin
        r_rsp_data   <= '0;
        r_rsp_low2   <= io.req_addr[1:0];
        r_rsp_option <= io.req_option;
      end
    end else if (w_busy) begin
      if (io.flush) begin
        r_flushed <= 1'b1;
      end
      if (io.bus_ack || w_timeout) begin
        r_berr <= w_timeout;
        if (!w_drop) begin
          r_rsp_data   <= (r_we || w_timeout) ? 32'd0 : io.bus_rdata;
          r_rsp_low2   <= r_addr[1:0];
          r_rsp_option <= r_option;
        end
      end
    end
  end

  always_comb begin
    w_byteen = 4'b0000;
    if (r_we) begin
      unique case (r_size)
        2'b00:   w_byteen = 4'b0001 << r_addr[1:0];
        2'b01:   w_byteen = 4'b0011 << r_addr[1:0];
        default: w_byteen = 4'b1111;
      endcase
    end
  end

  always_comb begin
    w_wdata = r_wdata;
    unique case (r_size)
      2'b00:   w_wdata = {4{r_wdata[7:0]}};
      2'b01:   w_wdata = {2{r_wdata[15:0]}};
      default: w_wdata = r_wdata;
    endcase
  end

  assign io.req_ready  = (r_state == IDLE);
  assign io.bus_req    = w_busy;
  assign io.bus_we     = w_busy && r_we;
  assign io.bus_addr   = w_busy ? {r_addr[31:2], 2'b00} : 32'd0;
  assign io.bus_byteen = w_busy ? w_byteen : 4'b0000;
  assign io.bus_wdata  = w_busy ? w_wdata : 32'd0;

  assign w_show = (r_state == RESP) && !r_flushed && !io.flush;

  assign io.rsp_valid        = w_show;
  assign io.rsp_data         = r_rsp_data;
  assign io.rsp_addr_low2bit = r_rsp_low2;
  assign io.rsp_option       = r_rsp_option;
  assign io.rsp_adel         = w_show && r_adel;
  assign io.rsp_ades         = w_show && r_ades;
`ifdef MEM_TIMEOUT_EN
  assign io.rsp_bus_err      = w_show && r_berr;
`else
  assign io.rsp_bus_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Random and directed stimulus for mem_access_unit against a transaction model.
module tb_mem_access_unit;

  logic clk;
  logic reset_n;

  mem_access_unit_if ifc ();

  mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (ifc)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1 << 30;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_data = 32'd0;
  logic [1:0]  last_low2 = 2'd0;
  logic [2:0]  last_opt  = 3'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks one whole transaction; d = BUSY cycle index carrying ack,
  // fb = BUSY cycle index carrying flush (-1 none), fr = flush in RESP.
  task automatic do_op(input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size,
                       input logic [2:0] opt, input logic [31:0] rd,
                       input int d, input int fb, input bit fr);
    bit aligned;
    bit fl;
    bit timed;
    bit show;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ed;
    aligned = (size == 2'd0) ||
              (size == 2'd1 && addr % 2 == 0) ||
              (size >= 2'd2 && addr % 4 == 0);
    if (!we)             be = 4'd0;
    else if (size == 0)  be = 4'(1 << (addr % 4));
    else if (size == 1)  be = 4'(3 << (addr % 4));
    else                 be = 4'hF;
    if (size == 0)      wd = {24'd0, wdata[7:0]} * 32'h01010101;
    else if (size == 1) wd = {16'd0, wdata[15:0]} * 32'h00010001;
    else                wd = wdata;
    fl = 1'b0;
    timed = 1'b0;

    chk("ready_idle", ifc.req_ready, 1);
    ifc.req_valid  = 1'b1;
    ifc.req_we     = we;
    ifc.req_addr   = addr;
    ifc.req_wdata  = wdata;
    ifc.req_size   = size;
    ifc.req_option = opt;
    step();
    ifc.req_valid = 1'b0;

    if (aligned) begin
      for (int i = 0; i <= d; i++) begin
        chk("bus_req", ifc.bus_req, 1);
        chk("bus_addr", ifc.bus_addr, addr & 32'hFFFF_FFFC);
        chk("bus_be", ifc.bus_byteen, be);
        chk("bus_we", ifc.bus_we, we);
        if (we) chk("bus_wd", ifc.bus_wdata, wd);
        chk("ready_busy", ifc.req_ready, 0);
        chk("rsp_busy", ifc.rsp_valid, 0);
        if (i == TO - 1 && i < d) timed = 1'b1;
        if (i == d) begin
          ifc.bus_ack   = 1'b1;
          ifc.bus_rdata = rd;
        end
        if (i == fb) begin
          ifc.flush = 1'b1;
          fl = 1'b1;
        end
        step();
        ifc.flush   = 1'b0;
        ifc.bus_ack = 1'b0;
        if (timed) break;
      end
    end

    chk("bus_req_resp", ifc.bus_req, 0);
    if (fr) begin
      ifc.flush = 1'b1;
      #1;
    end
    show = !fl && !fr;
    ed = (!aligned || we || timed) ? 32'd0 : rd;
    chk("rsp_valid", ifc.rsp_valid, show);
    chk("rsp_adel", ifc.rsp_adel, show && !aligned && !we);
    chk("rsp_ades", ifc.rsp_ades, show && !aligned && we);
    chk("rsp_berr", ifc.rsp_bus_err, show && timed);
    if (!fl) begin
      last_data = ed;
      last_low2 = addr[1:0];
      last_opt  = opt;
    end
    if (show) begin
      chk("rsp_data", ifc.rsp_data, ed);
      chk("rsp_low2", ifc.rsp_addr_low2bit, addr[1:0]);
      chk("rsp_opt", ifc.rsp_option, opt);
    end
    step();
    ifc.flush = 1'b0;
    chk("rsp_done", ifc.rsp_valid, 0);
    chk("ready_back", ifc.req_ready, 1);
    chk("data_hold", ifc.rsp_data, last_data);
    chk("low2_hold", ifc.rsp_addr_low2bit, last_low2);
    chk("flag_idle", {ifc.rsp_adel, ifc.rsp_ades, ifc.rsp_bus_err}, 0);
  endtask

  initial begin
    logic [31:0] a;
    reset_n        = 1'b0;
    ifc.req_valid  = 1'b0;
    ifc.req_we     = 1'b0;
    ifc.req_addr   = '0;
    ifc.req_wdata  = '0;
    ifc.req_size   = '0;
    ifc.req_option = '0;
    ifc.flush      = 1'b0;
    ifc.bus_ack    = 1'b0;
    ifc.bus_rdata  = '0;
    #12;
    chk("rst_ready", ifc.req_ready, 1);
    chk("rst_bus_req", ifc.bus_req, 0);
    chk("rst_bus_addr", ifc.bus_addr, 0);
    chk("rst_bus_be", ifc.bus_byteen, 0);
    chk("rst_bus_wd", ifc.bus_wdata, 0);
    chk("rst_rsp", ifc.rsp_valid, 0);
    chk("rst_data", ifc.rsp_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    do_op(0, 32'h1000, 0, 2'd2, 3'd0, 32'hDEADBEEF, 2, -1, 0);
    do_op(1, 32'h2003, 32'hA5, 2'd0, 3'd1, 0, 0, -1, 0);
    do_op(0, 32'h3001, 0, 2'd1, 3'd5, 0, 0, -1, 0);
    do_op(1, 32'h3002, 32'h1234, 2'd2, 3'd2, 0, 0, -1, 0);
    do_op(0, 32'h4000, 0, 2'd2, 3'd3, 32'h55AA55AA, 3, 1, 0);
    do_op(1, 32'h4002, 32'hBEEF, 2'd1, 3'd4, 0, 1, -1, 0);
    do_op(0, 32'h4004, 0, 2'd3, 3'd6, 32'h0BADF00D, 0, 0, 0);
    do_op(0, 32'h4008, 0, 2'd2, 3'd7, 32'h12345678, 1, -1, 1);
    do_op(0, 32'h5000, 0, 2'd2, 3'd1, 32'hCAFEF00D, 20, -1, 0);

    // flush together with req_valid in IDLE must not accept
    ifc.req_valid = 1'b1;
    ifc.flush     = 1'b1;
    ifc.req_addr  = 32'h6000;
    ifc.req_size  = 2'd2;
    step();
    chk("flush_idle_ready", ifc.req_ready, 1);
    chk("flush_idle_bus", ifc.bus_req, 0);
    ifc.req_valid = 1'b0;
    ifc.flush     = 1'b0;
    do_op(0, 32'h6004, 0, 2'd0, 3'd2, 32'h000000FF, 0, -1, 0);

    // asynchronous reset in the middle of BUSY
    ifc.req_valid = 1'b1;
    ifc.req_we    = 1'b0;
    ifc.req_addr  = 32'h7000;
    ifc.req_size  = 2'd2;
    step();
    ifc.req_valid = 1'b0;
    step();
    chk("pre_rst_bus_req", ifc.bus_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_bus_req", ifc.bus_req, 0);
    chk("arst_ready", ifc.req_ready, 1);
    chk("arst_addr", ifc.bus_addr, 0);
    @(negedge clk);
    reset_n = 1'b1;
    ifc.bus_ack   = 1'b1;
    ifc.bus_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("late_ack_rsp", ifc.rsp_valid, 0);
      chk("late_ack_bus", ifc.bus_req, 0);
      chk("late_ack_ready", ifc.req_ready, 1);
    end
    ifc.bus_ack = 1'b0;
    chk("late_ack_data", ifc.rsp_data, 0);
    last_data = 32'd0;
    last_low2 = 2'd0;
    last_opt  = 3'd0;

    for (int k = 0; k < 60; k++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_op(1'($urandom_range(0, 1)), a, $urandom,
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 6),
            ($urandom_range(0, 5) == 0) ? $urandom_range(0, 6) : -1,
            1'($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: BUSY cycles without bus_ack before a bus error (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  in  1  M-stage memory operation present.
REQ-005 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-006 SHALL have port req_addr  in  32  byte address.
REQ-007 SHALL have port req_wdata  in  32  store data, right-justified.
REQ-008 SHALL have port req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-009 SHALL have port req_option  in  3  load-extension code, passed through to the load extender unchanged.
REQ-010 SHALL have port flush  in  1  discard the current/incoming operation.
REQ-011 SHALL have port req_ready  out  1  unit can accept; low = pipeline stall.
REQ-012 SHALL have ports bus_req out 1, bus_we out 1, bus_addr out 32, bus_byteen out 4, bus_wdata out 32, bus_ack in 1, bus_rdata in 32.
REQ-013 SHALL have ports rsp_valid out 1, rsp_data out 32, rsp_addr_low2bit out 2, rsp_option out 3, rsp_adel out 1, rsp_ades out 1, rsp_bus_err out 1.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL accept a request at a rising edge in IDLE when req_valid=1 and flush=0, latching we, addr, wdata, size, option.
REQ-016 SHALL flag misalignment (half with addr[0]=1, word with addr[1:0]!=0) and on accept go directly to RESP with rsp_adel (load) or rsp_ades (store) = 1 and no bus transaction.
REQ-017 SHALL on aligned accept go to BUSY, driving bus_req=1 and bus_addr = {addr[31:2],2'b00} held stable until the bus_ack cycle.
REQ-018 SHALL drive bus_byteen: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; loads 4'b0000.
REQ-019 SHALL drive bus_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-020 SHALL in BUSY, on the edge where bus_ack=1, capture bus_rdata (loads) and go to RESP; stores capture 0.
REQ-021 SHALL in RESP assert rsp_valid for exactly one cycle with rsp_data, rsp_addr_low2bit = addr[1:0], rsp_option, exception flags, then return to IDLE.
REQ-022 SHALL give minimum latency accept-edge to rsp_valid of 2 cycles (ack in first BUSY cycle); misaligned 1 cycle.
REQ-023 SHALL on flush in BUSY complete the bus transaction but suppress rsp_valid and all rsp flags; flush in RESP suppresses that response.
REQ-024 SHALL on flush and req_valid together in IDLE not accept.
REQ-025 SHALL hold rsp_data/rsp_addr_low2bit/rsp_option at last value outside RESP; flags 0 outside RESP.

Reset
REQ-026 SHALL on reset_n=0, immediately and independent of clk, enter IDLE, clear all latched fields, drive bus_req=0, bus_we=0, bus_byteen=0, bus_addr=0, bus_wdata=0, rsp_*=0, req_ready=1.
REQ-027 SHALL on reset mid-BUSY drop bus_req asynchronously and ignore any later bus_ack until a new accept.

Configuration
REQ-028 SHALL with MEM_TIMEOUT_EN defined count BUSY cycles; at TIMEOUT_CYCLES without bus_ack drop bus_req, go RESP with rsp_bus_err=1, rsp_data=0; counter clears on each accept.
REQ-029 SHALL with MEM_TIMEOUT_EN undefined wait in BUSY indefinitely and tie rsp_bus_err to 0.

Verification
REQ-030 Load word addr 0x1000, ack after 3 BUSY cycles, rdata 0xDEADBEEF -> byteen 0000, req_ready low 4 cycles, rsp_data 0xDEADBEEF, low2bit 00.
REQ-031 Store byte addr 0x2003 wdata 0x000000A5 -> bus_addr 0x2000, byteen 1000, wdata 0xA5A5A5A5, rsp_valid 1 cycle, flags 0.
REQ-032 Load half addr 0x3001 -> no bus_req, rsp_adel=1 one cycle after accept; store word addr 0x3002 -> rsp_ades=1.
REQ-033 Flush asserted in BUSY of load 0x4000 -> bus completes on ack, rsp_valid stays 0, next request accepted in IDLE.
REQ-034 reset_n low mid-BUSY -> bus_req 0 same cycle, late bus_ack ignored, req_ready 1.
REQ-035 With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> bus_req drops after 16 BUSY cycles, rsp_bus_err=1, rsp_data 0.
